// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder/subtractor: operand conditioning,
// signed-overflow detection and parameter legality.
package adder_pkg;

  // Subtraction is A + ~B + 1, so B is inverted bitwise and the incoming
  // carry is flipped (borrow-in 1 becomes carry-in 0).
  function automatic logic eff_b_bit(input logic b, input logic sub);
    return b ^ sub;
  endfunction

  function automatic logic eff_cin(input logic carry, input logic sub);
    return carry ^ sub;
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  function automatic bit params_legal(input int width, input int chunk);
    return (chunk >= 2) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// One CHUNK-bit carry-lookahead slice: every carry is a flat sum of
// generate terms qualified by the propagates above them.
module cla_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK-1:0] w_g;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK:0]   w_c;
  logic             w_term;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    w_c[0] = i_cin;
    for (int i = 0; i < CHUNK; i++) begin
      w_term = i_cin;
      for (int m = 0; m <= i; m++) w_term = w_term & w_p[m];
      w_c[i+1] = w_term;
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int m = j + 1; m <= i; m++) w_term = w_term & w_p[m];
        w_c[i+1] = w_c[i+1] | w_term;
      end
    end
  end

  assign o_sum  = w_p ^ w_c[CHUNK-1:0];
  assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/pipelined_adder_sub.sv
// Fully pipelined adder/subtractor: an input register followed by one
// carry-lookahead chunk per stage, with a single global stall.
module pipelined_adder_sub
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow
);

  localparam int STAGES = WIDTH / CHUNK;

  if (!params_legal(WIDTH, CHUNK)) begin : g_bad_params
    $error("pipelined_adder_sub: WIDTH must be a multiple of CHUNK and CHUNK >= 2");
  end

  // Index k holds what stage k has registered; stage 0 is the input register.
  logic [WIDTH-1:0] r_a [0:STAGES-1];
  logic [WIDTH-1:0] r_b [0:STAGES-1];
  logic [WIDTH-1:0] r_s [1:STAGES];
  logic             r_c [0:STAGES];
  logic             r_v [0:STAGES];
  logic             r_ovf;

  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;

  assign w_advance = !r_v[STAGES] || out_ready;

  always_comb begin
    w_b_eff = '0;
    for (int i = 0; i < WIDTH; i++) w_b_eff[i] = eff_b_bit(in_b[i], in_sub);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_v[0] <= 1'b0;
      r_c[0] <= 1'b0;
      r_a[0] <= '0;
      r_b[0] <= '0;
    end else if (w_advance) begin
      r_v[0] <= in_valid;
      r_c[0] <= eff_cin(in_carry, in_sub);
      r_a[0] <= in_a;
      r_b[0] <= w_b_eff;
    end
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    localparam int LO = (k - 1) * CHUNK;

    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;
    logic [WIDTH-1:0] w_sum_prev;
    logic [WIDTH-1:0] w_sum_next;

    cla_chunk #(.CHUNK(CHUNK)) u_cla (
      .i_a   (r_a[k-1][LO +: CHUNK]),
      .i_b   (r_b[k-1][LO +: CHUNK]),
      .i_cin (r_c[k-1]),
      .o_sum (w_chunk_sum),
      .o_cout(w_chunk_cout)
    );

    if (k == 1) begin : g_first
      assign w_sum_prev = '0;
    end else begin : g_chain
      assign w_sum_prev = r_s[k-1];
    end

    always_comb begin
      w_sum_next              = w_sum_prev;
      w_sum_next[LO +: CHUNK] = w_chunk_sum;
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        r_v[k] <= 1'b0;
        r_c[k] <= 1'b0;
        r_s[k] <= '0;
      end else if (w_advance) begin
        r_v[k] <= r_v[k-1];
        r_c[k] <= w_chunk_cout;
        r_s[k] <= w_sum_next;
      end
    end

    if (k < STAGES) begin : g_fwd
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          r_a[k] <= '0;
          r_b[k] <= '0;
        end else if (w_advance) begin
          r_a[k] <= r_a[k-1];
          r_b[k] <= r_b[k-1];
        end
      end
    end else begin : g_last
      // The top chunk is resolved here, so the sign bits are all available.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          r_ovf <= 1'b0;
        end else if (w_advance) begin
          r_ovf <= signed_ovf(r_a[k-1][WIDTH-1], r_b[k-1][WIDTH-1], w_chunk_sum[CHUNK-1]);
        end
      end
    end
  end

  assign in_ready     = w_advance;
  assign out_valid    = r_v[STAGES];
  assign out_sum      = r_s[STAGES];
  assign out_carry    = r_c[STAGES];
  assign out_overflow = r_ovf;

endmodule
